// File: rtl/dlx_pipe_pkg.sv
// Shared definitions for the DLX pipeline: the IF/ID packet layout and the NOP bubble word.
package dlx_pipe_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h5400_0000;
   localparam int          PKT_W     = 96;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pcplus4;
      logic [31:0] instr;
   } fetch_pkt_t;

endpackage

// File: rtl/fdb_storage.sv
// Packet storage for the fetch/decode buffer: one synchronous write port, one async read port.
module fdb_storage
   import dlx_pipe_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [PKT_W-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [PKT_W-1:0] rdata
);

   logic [PKT_W-1:0] mem [DEPTH];

   // Data only; validity is tracked by the caller's count, so no reset here.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// Elastic IF/ID boundary: FIFO of fetch packets with decode backpressure and flush-to-bubble.
module fetch_decode_buffer
   import dlx_pipe_pkg::*;
#(
   parameter int          DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = dlx_pipe_pkg::NOP_INSTR
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              pc_in,
   input  logic [31:0]              pcplus4_in,
   input  logic [31:0]              instr_in,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     flush,
   output logic [31:0]              id_pc,
   output logic [31:0]              id_pcplus4,
   output logic [31:0]              id_instr,
   output logic                     id_valid,
   input  logic                     id_ready,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   fetch_pkt_t    wr_pkt;
   fetch_pkt_t    head_pkt;
   logic [PKT_W-1:0] head_raw;

   // Handshake decoded from registered count only, so fetch never sees a path from decode.
   assign in_ready = (count != CW'(DEPTH));
   assign id_valid = (count != '0);
   assign push     = in_valid & in_ready & ~flush;
   assign pop      = id_valid & id_ready & ~flush;

   assign wr_pkt = '{pc: pc_in, pcplus4: pcplus4_in, instr: instr_in};

   fdb_storage #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_storage (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (wr_pkt),
      .raddr (rd_ptr),
      .rdata (head_raw)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Stale entry contents are masked whenever the buffer is empty.
   assign head_pkt   = head_raw;
   assign id_pc      = id_valid ? head_pkt.pc      : 32'h0;
   assign id_pcplus4 = id_valid ? head_pkt.pcplus4 : 32'h0;
   assign id_instr   = id_valid ? head_pkt.instr   : NOP_INSTR;
   assign occupancy  = count;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench for fetch_decode_buffer: directed vector table, reset corner, random vs queue model.
module tb_fetch_decode_buffer;

   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h5400_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc_in = '0, pcplus4_in = '0, instr_in = '0;
   logic        in_valid = 1'b0, flush = 1'b0, id_ready = 1'b0;
   logic        in_ready, id_valid;
   logic [31:0] id_pc, id_pcplus4, id_instr;
   logic [$clog2(DEPTH):0] occupancy;

   int n_chk = 0;
   int n_fail = 0;

   logic [95:0] q[$];

   always #5 clk = ~clk;

   fetch_decode_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
      .clk(clk), .reset(reset), .pc_in(pc_in), .pcplus4_in(pcplus4_in), .instr_in(instr_in),
      .in_valid(in_valid), .in_ready(in_ready), .flush(flush), .id_pc(id_pc),
      .id_pcplus4(id_pcplus4), .id_instr(id_instr), .id_valid(id_valid), .id_ready(id_ready),
      .occupancy(occupancy)
   );

   typedef struct {
      logic        iv;
      logic        fl;
      logic        rdy;
      logic [31:0] pc;
      logic        ev;
      logic        er;
      logic [31:0] epc;
      int          eocc;
   } vec_t;

   vec_t vecs[14];

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return (pc == 32'h100) ? 32'h2001_0005 : (32'hA000_0000 | pc);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_out(input string tag, input logic ev, input logic er,
                            input logic [31:0] epc, input logic [31:0] epcp4,
                            input logic [31:0] eins, input int eocc);
      chk({tag, ".id_valid"},   32'(id_valid),  32'(ev));
      chk({tag, ".in_ready"},   32'(in_ready),  32'(er));
      chk({tag, ".occupancy"},  32'(occupancy), eocc);
      chk({tag, ".id_pc"},      id_pc,          epc);
      chk({tag, ".id_pcplus4"}, id_pcplus4,     epcp4);
      chk({tag, ".id_instr"},   id_instr,       eins);
   endtask

   task automatic check_model(input string tag);
      logic [95:0] h;
      if (q.size() != 0) begin
         h = q[0];
         check_out(tag, 1'b1, q.size() != DEPTH, h[95:64], h[63:32], h[31:0], q.size());
      end else begin
         check_out(tag, 1'b0, 1'b1, 32'h0, 32'h0, NOP, 0);
      end
   endtask

   // Reference: a bounded queue; capacity and head decided before the edge.
   task automatic model_step();
      bit can_take = (q.size() < DEPTH);
      bit has_head = (q.size() > 0);
      bit do_push  = in_valid && can_take && !flush;
      bit do_pop   = has_head && id_ready && !flush;
      if (flush) q.delete();
      else begin
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back({pc_in, pcplus4_in, instr_in});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_step();
      #1;
   endtask

   task automatic drive(input logic iv, input logic fl, input logic rdy, input logic [31:0] pc);
      in_valid   = iv;
      flush      = fl;
      id_ready   = rdy;
      pc_in      = pc;
      pcplus4_in = pc + 32'd4;
      instr_in   = instr_of(pc);
   endtask

   initial begin
      //          iv    fl    rdy   pc          ev    er    epc         occ
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h0,   0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h000, 1'b1, 1'b1, 32'h100, 1};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 1'b1, 32'h0,   0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h104, 1'b1, 1'b1, 32'h100, 1};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h108, 1'b1, 1'b0, 32'h100, 2};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h108, 1'b1, 1'b0, 32'h100, 2};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h108, 1'b1, 1'b1, 32'h104, 1};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h000, 1'b1, 1'b1, 32'h108, 1};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h10C, 1'b0, 1'b1, 32'h0,   0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h110, 1'b1, 1'b1, 32'h10C, 1};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 32'h114, 1'b1, 1'b0, 32'h10C, 2};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 32'h0,   0};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 32'h118, 1'b0, 1'b1, 32'h0,   0};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h000, 1'b0, 1'b1, 32'h0,   0};

      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check_out("reset", 1'b0, 1'b1, 32'h0, 32'h0, NOP, 0);
      tick();

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].iv, vecs[i].fl, vecs[i].rdy, vecs[i].pc);
         @(negedge clk);
         check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].epc,
                   vecs[i].ev ? vecs[i].epc + 32'd4 : 32'h0,
                   vecs[i].ev ? instr_of(vecs[i].epc) : NOP, vecs[i].eocc);
         tick();
      end

      // Asynchronous reset between edges with a full buffer.
      drive(1'b1, 1'b0, 1'b0, 32'h300);
      tick();
      drive(1'b1, 1'b0, 1'b0, 32'h304);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check_out("full_before_rst", 1'b1, 1'b0, 32'h300, 32'h304, instr_of(32'h300), 2);
      #2 reset = 1'b0;
      #1;
      check_out("async_rst", 1'b0, 1'b1, 32'h0, 32'h0, NOP, 0);
      q.delete();
      @(posedge clk);
      #1 reset = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 32'h200);
      @(negedge clk);
      check_out("post_rst_empty", 1'b0, 1'b1, 32'h0, 32'h0, NOP, 0);
      tick();
      drive(1'b0, 1'b0, 1'b1, 32'h0);
      @(negedge clk);
      check_out("post_rst_head", 1'b1, 1'b1, 32'h200, 32'h204, instr_of(32'h200), 1);
      tick();

      for (int i = 0; i < 600; i++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         id_ready   = ($urandom_range(0, 2) != 0);
         flush      = ($urandom_range(0, 15) == 0);
         pc_in      = $urandom & 32'hFFFF_FFFC;
         pcplus4_in = pc_in + 32'd4;
         instr_in   = $urandom;
         @(negedge clk);
         check_model($sformatf("rand%0d", i));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
